multi_bank_spram_param: RTL and testbench

Parametrised multi-bank single-port RAM, the successor to the fixed 4-bank 32x8 memory. Key changes from that memory:
- Configurable bank count, bank depth and data width.
- Only the addressed bank is enabled on each access.
- Byte write strobes.
- Read valid/latency tracking, with an optional output register.
- A hardware clear sequencer that zero-fills all banks after reset or on request.

It sits behind the AXI slave adapter as the storage core. It accepts one request per cycle when ready.

---
 rtl/multi_bank_spram_param.sv | 168 ++++++++++++++++
 tb/tb_multi_bank_spram_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_bank_spram_param.sv
// Parametrised multi-bank single-port RAM with byte strobes, read-latency tracking,
// optional output register and a zero-fill clear sequencer.
module multi_bank_spram_param #(
  parameter int NUM_BANKS      = 4,
  parameter int BANK_DEPTH     = 8,
  parameter int DATA_W         = 8,
  parameter int OUT_REG        = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ROW_W  = $clog2(BANK_DEPTH),
  localparam int BANK_W = $clog2(NUM_BANKS),
  localparam int ADDR_W = ROW_W + BANK_W,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic              clr_start,
  output logic              busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  typedef enum logic {S_CLEAR, S_READY} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  state_t             r_state;
  logic [ROW_W-1:0]   r_clr_cnt;
  logic               r_v1;
  logic [BANK_W-1:0]  r_sel1;

  logic               w_accept;
  logic               w_rd_accept;
  logic               w_clearing;
  logic [BANK_W-1:0]  w_bank;
  logic [ROW_W-1:0]   w_row;
  logic [DATA_W-1:0]  w_bank_rdata [NUM_BANKS];
  logic [DATA_W-1:0]  w_sel_rdata;

  // Gating with rst keeps ready low during reset even when no clear follows it.
  assign req_ready   = (r_state == S_READY) && !rst;
  assign busy        = (r_state == S_CLEAR);
  assign w_clearing  = (r_state == S_CLEAR);
  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_we;
  assign w_bank      = req_addr[ADDR_W-1:ROW_W];
  assign w_row       = req_addr[ROW_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RESET_STATE;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_cnt == ROW_W'(BANK_DEPTH - 1)) begin
            r_state   <= S_READY;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_READY: begin
          if (clr_start) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        default: r_state <= RESET_STATE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [DATA_W-1:0] r_mem [BANK_DEPTH];
      logic [DATA_W-1:0] r_rdata;
      logic              w_en;
      logic              w_wr;
      logic [ROW_W-1:0]  w_wrow;
      logic [DATA_W-1:0] w_wdata;
      logic [STRB_W-1:0] w_wstrb;

      assign w_en = w_accept && (w_bank == BANK_W'(gi));

      // The clear sequencer owns the write port of every bank while busy.
      always_comb begin
        w_wr    = w_en && req_we;
        w_wrow  = w_row;
        w_wdata = req_wdata;
        w_wstrb = req_wstrb;
        if (w_clearing) begin
          w_wr    = 1'b1;
          w_wrow  = r_clr_cnt;
          w_wdata = '0;
          w_wstrb = '1;
        end
      end

      always_ff @(posedge clk) begin
        if (w_wr) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_wstrb[b]) begin
              r_mem[w_wrow][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
          end
        end
        if (w_en && !req_we) begin
          r_rdata <= r_mem[w_row];
        end
      end

      assign w_bank_rdata[gi] = r_rdata;
    end
  endgenerate

  // Bank select travels with the read valid so the mux tracks the bank actually read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_sel1 <= '0;
    end else begin
      r_v1 <= w_rd_accept;
      if (w_rd_accept) begin
        r_sel1 <= w_bank;
      end
    end
  end

  assign w_sel_rdata = w_bank_rdata[r_sel1];

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              r_v2;
      logic [DATA_W-1:0] r_out;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v2  <= 1'b0;
          r_out <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_out <= w_sel_rdata;
          end
        end
      end
      assign rsp_valid = r_v2;
      assign rsp_rdata = r_out;
    end else begin : g_noreg
      logic [DATA_W-1:0] r_out;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out <= '0;
        end else if (r_v1) begin
          r_out <= w_sel_rdata;
        end
      end
      // Present fresh data directly; r_out keeps the last value between responses.
      assign rsp_valid = r_v1;
      assign rsp_rdata = r_v1 ? w_sel_rdata : r_out;
    end
  endgenerate

endmodule

// File: tb/tb_multi_bank_spram_param.sv
// Bench for multi_bank_spram_param: default instance (8-bit, latency 2) and a
// 32-bit latency-1 instance, checked every cycle against a behavioural model.
module tb_multi_bank_spram_param;

  logic clk;
  logic rst;

  logic        v     [2];
  logic        we    [2];
  logic        clr   [2];
  logic [4:0]  addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];

  logic        rdy0, bsy0, rv0;
  logic [7:0]  rd0;
  logic        rdy1, bsy1, rv1;
  logic [31:0] rd1;

  logic        ready_a [2];
  logic        busy_a  [2];
  logic        rv_a    [2];
  logic [31:0] rd_a    [2];

  int checks;
  int failures;
  logic [7:0] cap0[$];

  multi_bank_spram_param u_dut (
    .clk(clk), .rst(rst),
    .req_valid(v[0]), .req_ready(rdy0), .req_we(we[0]), .req_addr(addr[0]),
    .req_wdata(wdata[0][7:0]), .req_wstrb(wstrb[0][0:0]), .clr_start(clr[0]),
    .busy(bsy0), .rsp_valid(rv0), .rsp_rdata(rd0)
  );

  multi_bank_spram_param #(.DATA_W(32), .OUT_REG(0)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(v[1]), .req_ready(rdy1), .req_we(we[1]), .req_addr(addr[1]),
    .req_wdata(wdata[1]), .req_wstrb(wstrb[1]), .clr_start(clr[1]),
    .busy(bsy1), .rsp_valid(rv1), .rsp_rdata(rd1)
  );

  always_comb begin
    ready_a[0] = rdy0; busy_a[0] = bsy0; rv_a[0] = rv0; rd_a[0] = {24'h0, rd0};
    ready_a[1] = rdy1; busy_a[1] = bsy1; rv_a[1] = rv1; rd_a[1] = rd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: flat memory per instance, clear = countdown of cycles,
  // reads emerge a fixed number of cycles after acceptance.
  logic [31:0] mem_m   [2][32];
  int          clr_left[2];
  logic        p1v     [2];
  logic [31:0] p1d     [2];
  logic        p2v     [2];
  logic [31:0] p2d     [2];
  logic [31:0] last_d  [2];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s, input int nb);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < nb; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        clr_left[k] <= 8;
        p1v[k] <= 1'b0;
        p2v[k] <= 1'b0;
        last_d[k] <= 32'h0;
      end else begin
        if (clr_left[k] != 0) begin
          for (int b = 0; b < 4; b++) mem_m[k][b*8 + (8 - clr_left[k])] <= 32'h0;
          clr_left[k] <= clr_left[k] - 1;
        end else begin
          if (v[k] && we[k])
            mem_m[k][addr[k]] <= merge(mem_m[k][addr[k]], wdata[k], wstrb[k], (k == 0) ? 1 : 4);
          if (clr[k]) clr_left[k] <= 8;
        end
        p1v[k] <= (clr_left[k] == 0) && v[k] && !we[k];
        p1d[k] <= mem_m[k][addr[k]];
        p2v[k] <= p1v[k];
        p2d[k] <= p1d[k];
        if (k == 0) begin
          if (p1v[k]) last_d[k] <= p1d[k];
        end else if ((clr_left[k] == 0) && v[k] && !we[k]) begin
          last_d[k] <= mem_m[k][addr[k]];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("k%0d_ready", k), {31'h0, ready_a[k]}, {31'h0, !rst && clr_left[k] == 0});
      check($sformatf("k%0d_busy", k), {31'h0, busy_a[k]}, {31'h0, clr_left[k] != 0});
      check($sformatf("k%0d_rsp_valid", k), {31'h0, rv_a[k]}, {31'h0, (k == 0) ? p2v[k] : p1v[k]});
      check($sformatf("k%0d_rsp_rdata", k), rd_a[k], (k == 0) ? (last_d[k] & 32'hFF) : last_d[k]);
    end
    if (rv0) cap0.push_back(rd0);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic req(input int k, input logic vv, input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic c);
    v[k] = vv; we[k] = w; addr[k] = a; wdata[k] = d; wstrb[k] = s; clr[k] = c;
    $display("req k=%0d valid=%0b we=%0b addr=%0d wdata=%h wstrb=%h clr=%0b", k, vv, w, a, d, s, c);
    @(posedge clk); #1;
    v[k] = 1'b0; we[k] = 1'b0; clr[k] = 1'b0;
  endtask

  task automatic read_lat(input int k, input logic [4:0] a, output int lat, output logic [31:0] d);
    v[k] = 1'b1; we[k] = 1'b0; addr[k] = a;
    @(posedge clk); #1;
    v[k] = 1'b0;
    lat = 1;
    while (!rv_a[k] && lat < 6) begin @(posedge clk); #1; lat++; end
    d = rd_a[k];
    $display("read k=%0d addr=%0d latency=%0d rdata=%h", k, a, lat, d);
  endtask

  task automatic count_busy(input int k, output int n);
    n = 0;
    while (busy_a[k] && n < 40) begin @(posedge clk); #1; n++; end
  endtask

  initial begin
    int n;
    int lat;
    int nz;
    logic [31:0] d;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v[k] = 0; we[k] = 0; clr[k] = 0; addr[k] = 0; wdata[k] = 0; wstrb[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, rdy0}, 32'h0);
    check("rst_busy", {31'h0, bsy0}, 32'h1);
    check("rst_rsp_valid", {31'h0, rv0}, 32'h0);
    check("rst_rdata", {24'h0, rd0}, 32'h0);
    rst = 1'b0;

    // Test 1: clear after reset, then everything reads zero with latency 2.
    count_busy(0, n);
    check("t1_busy_cycles", n, 8);
    check("t1_ready_after", {31'h0, rdy0}, 32'h1);
    cap0.delete();
    for (int a = 0; a < 32; a++) req(0, 1, 0, 5'(a), 0, 0, 0);
    idle(3);
    check("t1_rsp_count", cap0.size(), 32);
    nz = 0;
    foreach (cap0[i]) if (cap0[i] != 8'h00) nz++;
    check("t1_nonzero_rsp", nz, 0);
    read_lat(0, 5'd0, lat, d);
    check("t1_latency", lat, 2);

    // Test 2: same row in banks 0 and 1, back-to-back reads, bank 2 untouched.
    req(0, 1, 1, 5'd5, 32'hA5, 4'h1, 0);
    req(0, 1, 1, 5'd13, 32'h3C, 4'h1, 0);
    cap0.delete();
    req(0, 1, 0, 5'd5, 0, 0, 0);
    req(0, 1, 0, 5'd13, 0, 0, 0);
    idle(3);
    check("t2_rsp_count", cap0.size(), 2);
    if (cap0.size() == 2) begin
      check("t2_rsp0", {24'h0, cap0[0]}, 32'hA5);
      check("t2_rsp1", {24'h0, cap0[1]}, 32'h3C);
    end
    read_lat(0, 5'd21, lat, d);
    check("t2_bank2_row5", d, 32'h0);

    // Test 3: byte strobes on the 32-bit, latency-1 instance.
    req(1, 1, 1, 5'd2, 32'h11223344, 4'hF, 0);
    req(1, 1, 1, 5'd2, 32'hAABBCCDD, 4'b0101, 0);
    read_lat(1, 5'd2, lat, d);
    check("t3_latency", lat, 1);
    check("t3_strobe_merge", d, 32'h11BB33DD);
    req(1, 1, 1, 5'd2, 32'hFFFFFFFF, 4'h0, 0);
    read_lat(1, 5'd2, lat, d);
    check("t3_zero_strobe", d, 32'h11BB33DD);

    // Test 4: write then read same address on consecutive cycles.
    req(1, 1, 1, 5'd7, 32'hCAFEF00D, 4'hF, 0);
    read_lat(1, 5'd7, lat, d);
    check("t4_latency", lat, 1);
    check("t4_wr_then_rd", d, 32'hCAFEF00D);

    // Test 5: read with clr_start, extra clr_start during clear is ignored.
    req(0, 1, 1, 5'd31, 32'hFF, 4'h1, 0);
    cap0.delete();
    req(0, 1, 0, 5'd31, 0, 0, 1);
    n = 0;
    while (busy_a[0] && n < 40) begin
      clr[0] = (n == 3);
      @(posedge clk); #1;
      n++;
    end
    clr[0] = 1'b0;
    check("t5_busy_cycles", n, 8);
    check("t5_rsp_count", cap0.size(), 1);
    if (cap0.size() == 1) check("t5_preclear_data", {24'h0, cap0[0]}, 32'hFF);
    read_lat(0, 5'd31, lat, d);
    check("t5_after_clear", d, 32'h0);

    // Test 6a: reset with a read in flight drops the response.
    req(0, 1, 1, 5'd5, 32'h5A, 4'h1, 0);
    read_lat(0, 5'd5, lat, d);
    check("t6_prime", d, 32'h5A);
    idle(1);
    cap0.delete();
    req(0, 1, 0, 5'd5, 0, 0, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'h0, rv0}, 32'h0);
    check("t6_rst_rdata", {24'h0, rd0}, 32'h0);
    check("t6_rst_ready", {31'h0, rdy0}, 32'h0);
    check("t6_rst_busy", {31'h0, bsy0}, 32'h1);
    idle(2);
    rst = 1'b0;
    count_busy(0, n);
    check("t6_busy_cycles", n, 8);
    check("t6_no_rsp", cap0.size(), 0);

    // Test 6b: reset at clear row 3 restarts a full clear.
    req(0, 0, 0, 5'd0, 0, 0, 1);
    idle(3);
    rst = 1'b1;
    #1;
    check("t6b_rst_busy", {31'h0, bsy0}, 32'h1);
    check("t6b_rst_ready", {31'h0, rdy0}, 32'h0);
    idle(1);
    rst = 1'b0;
    count_busy(0, n);
    check("t6b_busy_cycles", n, 8);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
